// File: rtl/multicycle_control_unit_pkg.sv
// ------------------------------------------------------------------
// cu_pkg: opcodes, state, ALU control encodings and opcode classes
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package cu_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef struct packed {
    logic rtype;
    logic load;
    logic store;
    logic imm;
    logic branch;
    logic illegal;
  } op_class_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_unit_decoder.sv
// ------------------------------------------------------------------
// control_decoder: one-hot instruction class from a 7-bit opcode
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module control_decoder
  import cu_pkg::*;
(
  input  logic [6:0] op,
  output op_class_t  cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE:  cls.rtype   = 1'b1;
      OP_LOAD:   cls.load    = 1'b1;
      OP_STORE:  cls.store   = 1'b1;
      OP_IMM:    cls.imm     = 1'b1;
      OP_BRANCH: cls.branch  = 1'b1;
      default:   cls.illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ------------------------------------------------------------------
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer with trap
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       Branch,
  output logic       instr_done,
  output logic       illegal,
  output logic [2:0] state
);

  localparam int unsigned CNT_W = ($clog2(MEM_TIMEOUT + 1) < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       op_q, op_d;
  logic [6:0]       dec_op;
  op_class_t        cls;
  logic             timeout;

  // DECODE classifies the live opcode; every later state uses the latched one.
  assign dec_op  = (state_q == S_DECODE) ? opcode : op_q;
  assign timeout = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign state   = state_q;

  control_decoder u_decoder (
    .op  (dec_op),
    .cls (cls)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      S_FETCH, S_MEM: begin
        if (mem_ready) begin
          cnt_d = '0;
          if (state_q == S_FETCH) state_d = S_DECODE;
          else if (cls.load)      state_d = S_WB;
          else                    state_d = S_FETCH;
        end else if (timeout) begin
          cnt_d   = '0;
          state_d = S_TRAP;
        end else if (MEM_TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        op_d = opcode;
        if (cls.illegal)     state_d = S_TRAP;
        else if (cls.branch) state_d = S_BRANCH;
        else                 state_d = S_EXEC;
      end
      S_EXEC: begin
        if (cls.load || cls.store)     state_d = S_MEM;
        else if (cls.rtype || cls.imm) state_d = S_WB;
        else                           state_d = S_TRAP;
      end
      S_WB, S_BRANCH: state_d = S_FETCH;
      default:        state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RS2;
    ALUOp      = ALU_ADD;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    Branch     = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_IMM;
      S_EXEC: begin
        ALUSrcA = 1'b1;
        if (cls.rtype) begin
          ALUSrcB = SRCB_RS2;
          ALUOp   = ALU_RTYPE;
        end else if (cls.imm) begin
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_ITYPE;
        end else begin
          ALUSrcB = SRCB_IMM;
        end
      end
      S_MEM: begin
        IorD       = 1'b1;
        MemRead    = cls.load;
        MemWrite   = cls.store;
        instr_done = mem_ready && cls.store;
      end
      S_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = cls.load;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALU_SUB;
        Branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
    // Outputs follow reset asynchronously so an aborted access never leaks a write.
    if (!rst_n) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_RS2;
      ALUOp      = ALU_ADD;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      Branch     = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

`default_nettype wire
